tri_fetch: RTL and testbench



---
 rtl/tri_fetch.sv | 271 +++++++++++++++++++++++++++
 tb/tb_tri_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_fetch.sv
// tri_fetch: walks instances and triangles, gathers three vertices plus transform per triangle.
// Optional macro TRI_FETCH_CULL_DEGEN_EN drops triangles whose indices repeat.
module tri_fetch #(
  parameter int MAX_VERT    = 8192,
  parameter int MAX_TRI     = 8192,
  parameter int MAX_INST    = 256,
  parameter int VIDX_W      = 8,
  parameter int TIDX_W      = 8,
  parameter int VTX_W       = 108,
  parameter int TRANS_W     = 288,
  parameter int VERT_ADDR_W = $clog2(MAX_VERT),
  parameter int TRI_ADDR_W  = $clog2(MAX_TRI),
  parameter int INST_W      = $clog2(MAX_INST),
  parameter int TRI_W       = 3 * VIDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INST_W:0]        inst_count,
  output logic [INST_W-1:0]      inst_id_rd,
  output logic [TRI_ADDR_W-1:0]  tri_addr_rd,
  output logic [VERT_ADDR_W-1:0] vert_addr_rd,
  input  logic [VERT_ADDR_W-1:0] vert_base_in,
  input  logic [TRI_ADDR_W-1:0]  tri_base_in,
  input  logic [TIDX_W-1:0]      tri_count_in,
  input  logic [TRANS_W-1:0]     transform_in,
  input  logic [TRI_W-1:0]       idx_tri_in,
  input  logic [VTX_W-1:0]       vert_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [VTX_W-1:0]       out_v0,
  output logic [VTX_W-1:0]       out_v1,
  output logic [VTX_W-1:0]       out_v2,
  output logic [TRANS_W-1:0]     out_transform,
  output logic [INST_W-1:0]      out_inst_id,
  output logic                   busy,
  output logic                   frame_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_INST,
    S_LOAD_XFORM,
    S_FETCH_TRI,
    S_CAP_TRI,
    S_FETCH_V0,
    S_FETCH_V1,
    S_FETCH_V2,
    S_CAP_V2,
    S_EMIT,
    S_NEXT_INST
  } state_t;

  state_t                 state_q, state_d;
  logic [INST_W:0]        inst_ctr_q, inst_ctr_d;
  logic [INST_W-1:0]      inst_id_q, inst_id_d;
  logic [TIDX_W-1:0]      tri_ctr_q, tri_ctr_d;
  logic [TIDX_W-1:0]      tri_count_q, tri_count_d;
  logic [VERT_ADDR_W-1:0] vert_base_q, vert_base_d;
  logic [TRI_ADDR_W-1:0]  tri_base_q, tri_base_d;
  logic [TRI_ADDR_W-1:0]  tri_addr_q, tri_addr_d;
  logic [VERT_ADDR_W-1:0] vert_addr_q, vert_addr_d;
  logic [VIDX_W-1:0]      idx1_q, idx1_d;
  logic [VIDX_W-1:0]      idx2_q, idx2_d;
  logic [VTX_W-1:0]       v0_q, v0_d;
  logic [VTX_W-1:0]       v1_q, v1_d;
  logic [VTX_W-1:0]       v2_q, v2_d;
  logic [TRANS_W-1:0]     xform_q, xform_d;
  logic [INST_W-1:0]      oid_q, oid_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [VIDX_W-1:0]      i0, i1, i2;
  logic [TIDX_W-1:0]      tri_nxt;
  logic [INST_W:0]        inst_nxt;

  assign i0       = idx_tri_in[VIDX_W-1:0];
  assign i1       = idx_tri_in[2*VIDX_W-1:VIDX_W];
  assign i2       = idx_tri_in[TRI_W-1:2*VIDX_W];
  assign tri_nxt  = tri_ctr_q + TIDX_W'(1);
  assign inst_nxt = inst_ctr_q + (INST_W+1)'(1);

`ifdef TRI_FETCH_CULL_DEGEN_EN
  logic degen;
  assign degen = (i0 == i1) || (i1 == i2) || (i0 == i2);
`endif

  // Vertex address wraps inside the vertex RAM.
  function automatic logic [VERT_ADDR_W-1:0] vaddr(
    input logic [VERT_ADDR_W-1:0] base,
    input logic [VIDX_W-1:0]      idx
  );
    return base + VERT_ADDR_W'(idx);
  endfunction

  // Next-state and datapath updates for the fetch sequencer.
  always_comb begin
    state_d     = state_q;
    inst_ctr_d  = inst_ctr_q;
    inst_id_d   = inst_id_q;
    tri_ctr_d   = tri_ctr_q;
    tri_count_d = tri_count_q;
    vert_base_d = vert_base_q;
    tri_base_d  = tri_base_q;
    tri_addr_d  = tri_addr_q;
    vert_addr_d = vert_addr_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    xform_d     = xform_q;
    oid_d       = oid_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (inst_count != '0) begin
            inst_ctr_d = '0;
            inst_id_d  = '0;
            busy_d     = 1'b1;
            state_d    = S_LOAD_INST;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD_INST: begin
        vert_base_d = vert_base_in;
        tri_base_d  = tri_base_in;
        tri_count_d = tri_count_in;
        if (tri_count_in == '0) state_d = S_NEXT_INST;
        else                    state_d = S_LOAD_XFORM;
      end
      S_LOAD_XFORM: begin
        xform_d    = transform_in;
        oid_d      = inst_id_q;
        tri_ctr_d  = '0;
        tri_addr_d = tri_base_q;
        state_d    = S_FETCH_TRI;
      end
      S_FETCH_TRI: begin
        state_d = S_CAP_TRI;
      end
      S_CAP_TRI: begin
        idx1_d = i1;
        idx2_d = i2;
`ifdef TRI_FETCH_CULL_DEGEN_EN
        if (degen) begin
          tri_ctr_d = tri_nxt;
          if (tri_nxt == tri_count_q) begin
            state_d = S_NEXT_INST;
          end else begin
            tri_addr_d = tri_base_q + TRI_ADDR_W'(tri_nxt);
            state_d    = S_FETCH_TRI;
          end
        end else begin
          vert_addr_d = vaddr(vert_base_q, i0);
          state_d     = S_FETCH_V0;
        end
`else
        vert_addr_d = vaddr(vert_base_q, i0);
        state_d     = S_FETCH_V0;
`endif
      end
      S_FETCH_V0: begin
        vert_addr_d = vaddr(vert_base_q, idx1_q);
        state_d     = S_FETCH_V1;
      end
      S_FETCH_V1: begin
        v0_d        = vert_in;
        vert_addr_d = vaddr(vert_base_q, idx2_q);
        state_d     = S_FETCH_V2;
      end
      S_FETCH_V2: begin
        v1_d    = vert_in;
        state_d = S_CAP_V2;
      end
      S_CAP_V2: begin
        v2_d    = vert_in;
        valid_d = 1'b1;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          valid_d   = 1'b0;
          tri_ctr_d = tri_nxt;
          if (tri_nxt == tri_count_q) begin
            state_d = S_NEXT_INST;
          end else begin
            tri_addr_d = tri_base_q + TRI_ADDR_W'(tri_nxt);
            state_d    = S_FETCH_TRI;
          end
        end
      end
      S_NEXT_INST: begin
        inst_ctr_d = inst_nxt;
        if (inst_nxt == inst_count) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          inst_id_d = inst_nxt[INST_W-1:0];
          state_d   = S_LOAD_INST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      inst_ctr_q  <= '0;
      inst_id_q   <= '0;
      tri_ctr_q   <= '0;
      tri_count_q <= '0;
      vert_base_q <= '0;
      tri_base_q  <= '0;
      tri_addr_q  <= '0;
      vert_addr_q <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      xform_q     <= '0;
      oid_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_ctr_q  <= inst_ctr_d;
      inst_id_q   <= inst_id_d;
      tri_ctr_q   <= tri_ctr_d;
      tri_count_q <= tri_count_d;
      vert_base_q <= vert_base_d;
      tri_base_q  <= tri_base_d;
      tri_addr_q  <= tri_addr_d;
      vert_addr_q <= vert_addr_d;
      idx1_q      <= idx1_d;
      idx2_q      <= idx2_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      xform_q     <= xform_d;
      oid_q       <= oid_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign inst_id_rd    = inst_id_q;
  assign tri_addr_rd   = tri_addr_q;
  assign vert_addr_rd  = vert_addr_q;
  assign out_valid     = valid_q;
  assign out_v0        = v0_q;
  assign out_v1        = v1_q;
  assign out_v2        = v2_q;
  assign out_transform = xform_q;
  assign out_inst_id   = oid_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_tri_fetch.sv
// tb_tri_fetch: directed frames against behavioural RAMs with a triangle scoreboard.
// Vertex and transform data encode their own address so mis-fetches are visible.
module tb_tri_fetch;
  localparam int VA = 13;
  localparam int TA = 13;
  localparam int IW = 8;
  localparam int VW = 108;
  localparam int XW = 288;
  localparam int TW = 24;
`ifdef TRI_FETCH_CULL_DEGEN_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW:0]   inst_count;
  logic [IW-1:0] inst_id_rd;
  logic [TA-1:0] tri_addr_rd;
  logic [VA-1:0] vert_addr_rd;
  logic [VA-1:0] vert_base_in;
  logic [TA-1:0] tri_base_in;
  logic [7:0]    tri_count_in;
  logic [XW-1:0] transform_in;
  logic [TW-1:0] idx_tri_in;
  logic [VW-1:0] vert_in;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_v0, out_v1, out_v2;
  logic [XW-1:0] out_transform;
  logic [IW-1:0] out_inst_id;
  logic          busy;
  logic          frame_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tri_fetch dut (
    .clk(clk), .rst(rst), .start(start), .inst_count(inst_count),
    .inst_id_rd(inst_id_rd), .tri_addr_rd(tri_addr_rd),
    .vert_addr_rd(vert_addr_rd), .vert_base_in(vert_base_in),
    .tri_base_in(tri_base_in), .tri_count_in(tri_count_in),
    .transform_in(transform_in), .idx_tri_in(idx_tri_in),
    .vert_in(vert_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_v0(out_v0), .out_v1(out_v1), .out_v2(out_v2),
    .out_transform(out_transform), .out_inst_id(out_inst_id),
    .busy(busy), .frame_done(frame_done)
  );

  logic [VA-1:0] vb_m  [256];
  logic [TA-1:0] tb_m  [256];
  logic [7:0]    tc_m  [256];
  logic [TW-1:0] tri_m [8192];

  function automatic logic [VW-1:0] vdat(input logic [VA-1:0] a);
    return {a, ~a, 69'h0, a};
  endfunction

  function automatic logic [XW-1:0] xf(input logic [IW-1:0] i);
    return {~i, 248'h0, i, ~i, i, ~i};
  endfunction

  assign vert_base_in = vb_m[inst_id_rd];
  assign tri_base_in  = tb_m[inst_id_rd];
  assign tri_count_in = tc_m[inst_id_rd];

  always @(posedge clk) begin
    transform_in <= xf(inst_id_rd);
    idx_tri_in   <= tri_m[tri_addr_rd];
    vert_in      <= vdat(vert_addr_rd);
  end

  typedef struct {
    logic [VW-1:0] v0;
    logic [VW-1:0] v1;
    logic [VW-1:0] v2;
    logic [XW-1:0] x;
    logic [IW-1:0] id;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [XW-1:0] obs,
                     input logic [XW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TW-1:0] ix3(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic push_frame(input int n);
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < int'(tc_m[i]); t++) begin
        logic [TA-1:0] ta;
        logic [TW-1:0] ix;
        logic [7:0]    a, b, c;
        exp_t          e;
        ta = tb_m[i] + TA'(t);
        ix = tri_m[ta];
        a  = ix[7:0];
        b  = ix[15:8];
        c  = ix[23:16];
        if (CULL && (a == b || b == c || a == c)) continue;
        e.v0 = vdat(vb_m[i] + VA'(a));
        e.v1 = vdat(vb_m[i] + VA'(b));
        e.v2 = vdat(vb_m[i] + VA'(c));
        e.x  = xf(IW'(i));
        e.id = IW'(i);
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input int n, input int stall_tri,
                           input int stall_len, input int gap);
    int hs, fd_cnt, fd_cyc, last_hs, stall_left, st, extra;
    bit busy_seen;
    exp_t e;
    logic [VW-1:0] s_v0, s_v1, s_v2;
    logic [XW-1:0] s_x;
    logic [VA-1:0] s_va;
    logic [TA-1:0] s_ta;
    hs = 0; fd_cnt = 0; fd_cyc = -1; last_hs = -1;
    stall_left = 0; st = 0; extra = 0; busy_seen = 1'b0;
    s_v0 = '0; s_v1 = '0; s_v2 = '0; s_x = '0; s_va = '0; s_ta = '0;
    push_frame(n);
    @(negedge clk);
    inst_count = (IW+1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 4000 && extra < 5; cyc++) begin
      if (busy) busy_seen = 1'b1;
      if (frame_done) begin
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (fd_cnt > 0) extra++;
      out_ready = 1'b1;
      if (st == 0 && stall_len > 0 && out_valid && hs == stall_tri) begin
        st = 1;
        stall_left = stall_len;
        s_v0 = out_v0; s_v1 = out_v1; s_v2 = out_v2; s_x = out_transform;
        s_va = vert_addr_rd; s_ta = tri_addr_rd;
      end
      if (st == 1) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          chk("stall_valid", XW'(out_valid), XW'(1));
          stall_left--;
        end else begin
          chk("stall_v0", XW'(out_v0), XW'(s_v0));
          chk("stall_v1", XW'(out_v1), XW'(s_v1));
          chk("stall_v2", XW'(out_v2), XW'(s_v2));
          chk("stall_xf", out_transform, s_x);
          chk("stall_vaddr", XW'(vert_addr_rd), XW'(s_va));
          chk("stall_taddr", XW'(tri_addr_rd), XW'(s_ta));
          st = 2;
        end
      end
      if (out_valid && out_ready) begin
        chk("emit_expected", XW'(sb.size() > 0), XW'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("v0", XW'(out_v0), XW'(e.v0));
          chk("v1", XW'(out_v1), XW'(e.v1));
          chk("v2", XW'(out_v2), XW'(e.v2));
          chk("xform", out_transform, e.x);
          chk("inst_id", XW'(out_inst_id), XW'(e.id));
        end
        if (gap > 0 && hs == 1) chk("tri_gap", XW'(cyc - last_hs), XW'(gap));
        last_hs = cyc;
        hs++;
      end
      @(negedge clk);
    end
    chk("sb_empty", XW'(sb.size()), XW'(0));
    chk("done_once", XW'(fd_cnt), XW'(1));
    chk("busy_end", XW'(busy), XW'(0));
    if (n == 0) begin
      chk("done_lat0", XW'(fd_cyc), XW'(1));
      chk("busy_never", XW'(busy_seen), XW'(0));
    end else begin
      chk("busy_seen", XW'(busy_seen), XW'(1));
      chk("done_after_hs",
          XW'((fd_cyc - last_hs) >= 1 && (fd_cyc - last_hs) <= 3), XW'(1));
    end
    sb.delete();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      vb_m[i] = '0; tb_m[i] = '0; tc_m[i] = '0;
    end
    for (int i = 0; i < 8192; i++) tri_m[i] = '0;
  endtask

  task automatic setup_basic();
    clear_mem();
    vb_m[0] = 13'd100; tb_m[0] = 13'd40; tc_m[0] = 8'd2;
    tri_m[40] = ix3(0, 1, 2);
    tri_m[41] = ix3(2, 1, 3);
  endtask

  initial begin
    bit fd_seen;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; inst_count = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", XW'(out_valid), XW'(0));
    chk("rst_busy", XW'(busy), XW'(0));
    chk("rst_done", XW'(frame_done), XW'(0));
    chk("rst_inst", XW'(inst_id_rd), XW'(0));
    chk("rst_taddr", XW'(tri_addr_rd), XW'(0));
    chk("rst_vaddr", XW'(vert_addr_rd), XW'(0));
    chk("rst_v0", XW'(out_v0), XW'(0));
    chk("rst_xf", out_transform, XW'(0));

    setup_basic();
    run_frame(1, -1, 0, 7);

    setup_basic();
    run_frame(1, 0, 10, 0);

    run_frame(0, -1, 0, 0);

    setup_basic();
    tc_m[1] = 8'd0;
    vb_m[2] = 13'd500; tb_m[2] = 13'd100; tc_m[2] = 8'd1;
    tri_m[100] = ix3(4, 5, 6);
    run_frame(3, -1, 0, 0);

    clear_mem();
    vb_m[0] = 13'd8190; tb_m[0] = 13'd8191; tc_m[0] = 8'd2;
    tri_m[8191] = ix3(1, 2, 3);
    tri_m[0]    = ix3(5, 6, 7);
    run_frame(1, -1, 0, 7);

    setup_basic();
    @(negedge clk);
    inst_count = 9'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", XW'(out_valid), XW'(0));
    chk("midrst_busy", XW'(busy), XW'(0));
    fd_seen = frame_done;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (frame_done) fd_seen = 1'b1;
    end
    chk("midrst_nodone", XW'(fd_seen), XW'(0));
    run_frame(1, -1, 0, 7);

    clear_mem();
    vb_m[0] = 13'd200; tb_m[0] = 13'd300; tc_m[0] = 8'd2;
    tri_m[300] = ix3(0, 0, 1);
    tri_m[301] = ix3(0, 1, 2);
    run_frame(1, -1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
